alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Requester-side driver for the 8-bit combinational ALU (rs/rt/opcode in; result/set/zero out). It accepts tagged operation requests over a valid/ready handshake and queues them in a small FIFO. It drives each operation onto the ALU, waits a configurable settle time, and samples the result. The result is returned, in order, over a valid/ready response handshake, with saturating activity counters. It sits between instruction control (or a bench driver) and the ALU.

Parameters:
DATA_W, 8, operand/result width
OP_W, 3, opcode width
TAG_W, 4, request tag width
FIFO_DEPTH, 4, request queue entries (power of 2, >=2)
ALU_LAT, 0, extra cycles to wait after driving operands before sampling (0..3)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_rs_i  in  DATA_W  operand rs
req_rt_i  in  DATA_W  operand rt
req_opcode_i  in  OP_W  ALU opcode
req_tag_i  in  TAG_W  tag, returned with response
rs_o  out  DATA_W  ALU rs operand
rt_o  out  DATA_W  ALU rt operand
opcode_o  out  OP_W  ALU opcode
alu_result_i  in  DATA_W  ALU result
set_i  in  1  ALU set flag
zero_i  in  1  ALU zero flag
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_result_o  out  DATA_W  captured result
rsp_set_o  out  1  captured set
rsp_zero_o  out  1  captured zero
rsp_tag_o  out  TAG_W  tag of this response
busy_o  out  1  FSM not IDLE or FIFO non-empty
op_count_o  out  16  completed responses, saturates at 0xFFFF
zero_count_o  out  16  completed responses with zero=1, saturates at 0xFFFF

Behaviour:
- Reset (rst_i high at an edge): FIFO flushed, FSM to IDLE, all outputs 0 except req_ready_o=1. Pending and in-flight ops are dropped, and no response for them ever appears.
- req_ready_o = FIFO not full (registered count). When full, no push occurs even if a pop happens the same cycle. Push and pop in the same cycle on a non-full FIFO: both happen, and the count is unchanged.
- Requests are executed and responded to strictly in FIFO order.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop at the edge, load the operand regs (rs_o/rt_o/opcode_o plus the tag), load wait_cnt=ALU_LAT, and go to EXEC.
  - EXEC: operand regs drive the ALU. If wait_cnt==0 at the edge, capture alu_result_i/set_i/zero_i and the tag into the response regs, set rsp_valid_o=1, and go to HOLD. Otherwise decrement wait_cnt.
  - HOLD: response regs are stable while rsp_valid_o=1 and !rsp_ready_i. On the handshake edge, clear rsp_valid_o. If the FIFO is non-empty at that edge, pop directly into EXEC (no IDLE bubble); otherwise go to IDLE.
- ALU operands are not cleared after an op. rs_o/rt_o/opcode_o hold their last values until the next pop.
- Latency: request accepted at edge E0 with the FSM idle → operands driven after E1 → rsp_valid_o high after edge E(2+ALU_LAT).
- Throughput with rsp_ready_i held high: one response per (2+ALU_LAT) cycles.
- Counters update on the response handshake edge. op_count_o is +1. zero_count_o is +1 if rsp_zero_o=1. Both saturate at 0xFFFF with no wrap.
- FIFO pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by a count (or an extra pointer bit).

Test Plan:
Bench ALU stub: result = rs ^ rt; zero = (result==0); set = (rs<rt unsigned).
1. Hold rst_i for 2 cycles → rsp_valid_o=0, busy_o=0, rs_o=rt_o=0, opcode_o=0, counters 0, req_ready_o=1.
2. ALU_LAT=0, rsp_ready_i=1, one request rs=0x55, rt=0xAA, op=3'b000, tag=5 → rsp_valid_o high 2 cycles after acceptance, result 0xFF, zero=0, set=1, tag=5, op_count_o=1, busy_o=0 afterward.
3. rsp_ready_i=0, push 6 requests (tags 0..5) → 5 accepted and req_ready_o low on the 6th. Then raise rsp_ready_i → tags 0,1,2,3,4,5 return in order, spaced 2 cycles apart, op_count_o=6.
4. rs=rt=0xFF, op=3'b111 → result 0x00, zero=1, set=0, zero_count_o increments by 1.
5. ALU_LAT=2, rs=0x0F, rt=0xF0 → rs_o/rt_o stable for 3 cycles, rsp_valid_o high 4 cycles after acceptance, result 0xFF.
6. Assert rst_i for 1 cycle while in HOLD with 3 queued requests → next cycle rsp_valid_o=0, busy_o=0, counters 0, req_ready_o=1, and no stale responses thereafter.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: requester-side driver for an 8-bit combinational ALU.
// Tagged requests are queued in a small FIFO and executed one at a time.
// The sequencer drives the operands, waits ALU_LAT extra cycles, and
// captures the ALU outputs. It then presents them in order on a valid/ready
// response port and keeps saturating activity counters.
module alu_op_sequencer #(
    parameter int DATA_W     = 8,
    parameter int OP_W       = 3,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ALU_LAT    = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [DATA_W-1:0] req_rs_i,
    input  logic [DATA_W-1:0] req_rt_i,
    input  logic [OP_W-1:0]   req_opcode_i,
    input  logic [TAG_W-1:0]  req_tag_i,
    output logic [DATA_W-1:0] rs_o,
    output logic [DATA_W-1:0] rt_o,
    output logic [OP_W-1:0]   opcode_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              set_i,
    input  logic              zero_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_result_o,
    output logic              rsp_set_o,
    output logic              rsp_zero_o,
    output logic [TAG_W-1:0]  rsp_tag_o,
    output logic              busy_o,
    output logic [15:0]       op_count_o,
    output logic [15:0]       zero_count_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 2 * DATA_W + OP_W + TAG_W;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [1:0]       LAT_LOAD = 2'(ALU_LAT);
    localparam logic [15:0]      CNT_SAT  = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    // request queue
    logic [ENT_W-1:0] fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;

    // control
    state_t           state_r;
    logic [1:0]       wait_r;
    logic             ready_r;
    logic             busy_r;
    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic             rsp_hs_s;
    logic             busy_next_s;

    // head-of-queue fields
    logic [ENT_W-1:0]  head_s;
    logic [DATA_W-1:0] head_rs_s;
    logic [DATA_W-1:0] head_rt_s;
    logic [OP_W-1:0]   head_op_s;
    logic [TAG_W-1:0]  head_tag_s;

    // operand and response registers
    logic [DATA_W-1:0] rs_r;
    logic [DATA_W-1:0] rt_r;
    logic [OP_W-1:0]   op_r;
    logic [TAG_W-1:0]  tag_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_result_r;
    logic              rsp_set_r;
    logic              rsp_zero_r;
    logic [TAG_W-1:0]  rsp_tag_r;
    logic [15:0]       op_cnt_r;
    logic [15:0]       zero_cnt_r;

    // Handshake qualifiers, queue occupancy lookahead and next busy state
    always_comb begin
        full_s     = (count_r == CNT_FULL);
        push_s     = req_valid_i & ~full_s;
        rsp_hs_s   = (state_r == ST_HOLD) & rsp_ready_i;
        pop_s      = (count_r != CNT_ZERO) & ((state_r == ST_IDLE) | rsp_hs_s);
        head_s     = fifo_mem_r[rd_ptr_r];
        head_rs_s  = head_s[ENT_W-1 -: DATA_W];
        head_rt_s  = head_s[ENT_W-DATA_W-1 -: DATA_W];
        head_op_s  = head_s[TAG_W+OP_W-1 -: OP_W];
        head_tag_s = head_s[TAG_W-1:0];

        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase

        busy_next_s = 1'b0;
        case (state_r)
            ST_IDLE: busy_next_s = pop_s;
            ST_EXEC: busy_next_s = 1'b1;
            ST_HOLD: busy_next_s = ~rsp_ready_i | pop_s;
            default: busy_next_s = 1'b0;
        endcase
        busy_next_s = busy_next_s | (count_next_s != CNT_ZERO);
    end

    // Queue storage: written on an accepted request, never cleared
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {req_rs_i, req_rt_i, req_opcode_i, req_tag_i};
        end
    end

    // Queue pointers, occupancy and the registered ready/busy outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            ready_r <= (count_next_s != CNT_FULL);
            busy_r  <= busy_next_s;
        end
    end

    // Execution FSM: issue operands, wait for the ALU, hold the response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            wait_r       <= 2'd0;
            rs_r         <= {DATA_W{1'b0}};
            rt_r         <= {DATA_W{1'b0}};
            op_r         <= {OP_W{1'b0}};
            tag_r        <= {TAG_W{1'b0}};
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= {DATA_W{1'b0}};
            rsp_set_r    <= 1'b0;
            rsp_zero_r   <= 1'b0;
            rsp_tag_r    <= {TAG_W{1'b0}};
            op_cnt_r     <= 16'd0;
            zero_cnt_r   <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        rs_r    <= head_rs_s;
                        rt_r    <= head_rt_s;
                        op_r    <= head_op_s;
                        tag_r   <= head_tag_s;
                        wait_r  <= LAT_LOAD;
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (wait_r == 2'd0) begin
                        rsp_result_r <= alu_result_i;
                        rsp_set_r    <= set_i;
                        rsp_zero_r   <= zero_i;
                        rsp_tag_r    <= tag_r;
                        rsp_valid_r  <= 1'b1;
                        state_r      <= ST_HOLD;
                    end else begin
                        wait_r <= wait_r - 2'd1;
                    end
                end
                ST_HOLD: begin
                    if (rsp_ready_i) begin
                        rsp_valid_r <= 1'b0;
                        if (op_cnt_r != CNT_SAT) begin
                            op_cnt_r <= op_cnt_r + 16'd1;
                        end
                        if (rsp_zero_r && (zero_cnt_r != CNT_SAT)) begin
                            zero_cnt_r <= zero_cnt_r + 16'd1;
                        end
                        // back-to-back issue: no IDLE bubble when work is queued
                        if (pop_s) begin
                            rs_r    <= head_rs_s;
                            rt_r    <= head_rt_s;
                            op_r    <= head_op_s;
                            tag_r   <= head_tag_s;
                            wait_r  <= LAT_LOAD;
                            state_r <= ST_EXEC;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = ready_r;
    assign busy_o       = busy_r;
    assign rs_o         = rs_r;
    assign rt_o         = rt_r;
    assign opcode_o     = op_r;
    assign rsp_valid_o  = rsp_valid_r;
    assign rsp_result_o = rsp_result_r;
    assign rsp_set_o    = rsp_set_r;
    assign rsp_zero_o   = rsp_zero_r;
    assign rsp_tag_o    = rsp_tag_r;
    assign op_count_o   = op_cnt_r;
    assign zero_count_o = zero_cnt_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (ALU_LAT=0 and ALU_LAT=2) share
// the request/response stimulus, each with its own XOR ALU stub.
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req_valid;
    logic [7:0] req_rs;
    logic [7:0] req_rt;
    logic [2:0] req_op;
    logic [3:0] req_tag;
    logic       rsp_ready;

    logic       ready0, set0, zero0, rv0, rset0, rzero0, busy0;
    logic [7:0] rs0, rt0, alu0, rr0;
    logic [2:0] op0;
    logic [3:0] rtag0;
    logic [15:0] opc0, zc0;

    logic       ready2, set2, zero2, rv2, rset2, rzero2, busy2;
    logic [7:0] rs2, rt2, alu2, rr2;
    logic [2:0] op2;
    logic [3:0] rtag2;
    logic [15:0] opc2, zc2;

    // ALU stubs
    assign alu0  = rs0 ^ rt0;
    assign zero0 = (alu0 == 8'h00);
    assign set0  = (rs0 < rt0);
    assign alu2  = rs2 ^ rt2;
    assign zero2 = (alu2 == 8'h00);
    assign set2  = (rs2 < rt2);

    alu_op_sequencer #(.ALU_LAT(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready0),
        .req_rs_i(req_rs), .req_rt_i(req_rt), .req_opcode_i(req_op), .req_tag_i(req_tag),
        .rs_o(rs0), .rt_o(rt0), .opcode_o(op0), .alu_result_i(alu0), .set_i(set0), .zero_i(zero0),
        .rsp_valid_o(rv0), .rsp_ready_i(rsp_ready), .rsp_result_o(rr0), .rsp_set_o(rset0),
        .rsp_zero_o(rzero0), .rsp_tag_o(rtag0), .busy_o(busy0), .op_count_o(opc0), .zero_count_o(zc0)
    );

    alu_op_sequencer #(.ALU_LAT(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready2),
        .req_rs_i(req_rs), .req_rt_i(req_rt), .req_opcode_i(req_op), .req_tag_i(req_tag),
        .rs_o(rs2), .rt_o(rt2), .opcode_o(op2), .alu_result_i(alu2), .set_i(set2), .zero_i(zero2),
        .rsp_valid_o(rv2), .rsp_ready_i(rsp_ready), .rsp_result_o(rr2), .rsp_set_o(rset2),
        .rsp_zero_o(rzero2), .rsp_tag_o(rtag2), .busy_o(busy2), .op_count_o(opc2), .zero_count_o(zc2)
    );

    typedef struct {
        logic [7:0] rs;
        logic [7:0] rt;
        logic [2:0] op;
        logic [3:0] tag;
        logic [7:0] res;
        logic       set;
        logic       zero;
    } vec_t;

    typedef struct packed {
        logic [7:0] rs;
        logic [7:0] rt;
        logic [3:0] tag;
    } txn_t;

    vec_t vecs [6];
    txn_t exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;
    int exp_ops  = 0;
    int exp_zeros = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // compare the response currently offered by dut0 with the oldest accepted request
    task automatic check_rsp(input string pfx);
        txn_t t;
        logic [7:0] r;
        check({pfx, "_expected_pending"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            t = exp_q.pop_front();
            r = t.rs ^ t.rt;
            check({pfx, "_result"}, 32'(rr0), 32'(r));
            check({pfx, "_set"}, 32'(rset0), 32'(t.rs < t.rt));
            check({pfx, "_zero"}, 32'(rzero0), 32'(r == 8'h00));
            check({pfx, "_tag"}, 32'(rtag0), 32'(t.tag));
            exp_ops++;
            if (r == 8'h00) exp_zeros++;
        end
    endtask

    initial begin
        int lat;
        int acc_n;
        int got;
        int last;
        int stale;
        logic acc;

        vecs[0] = '{8'h55, 8'hAA, 3'b000, 4'd5,  8'hFF, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 8'hFF, 3'b111, 4'd6,  8'h00, 1'b0, 1'b1};
        vecs[2] = '{8'h80, 8'h01, 3'b010, 4'd7,  8'h81, 1'b0, 1'b0};
        vecs[3] = '{8'h33, 8'h33, 3'b001, 4'd8,  8'h00, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 8'h01, 3'b100, 4'd9,  8'h01, 1'b1, 1'b0};
        vecs[5] = '{8'h0F, 8'hF0, 3'b011, 4'd10, 8'hFF, 1'b1, 1'b0};

        rst = 1'b1; req_valid = 1'b0; req_rs = 8'h00; req_rt = 8'h00;
        req_op = 3'b000; req_tag = 4'd0; rsp_ready = 1'b1;

        // 1. reset values
        tick(); tick();
        check("rst_rsp_valid", 32'(rv0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_rs", 32'(rs0), 32'd0);
        check("rst_rt", 32'(rt0), 32'd0);
        check("rst_opcode", 32'(op0), 32'd0);
        check("rst_op_count", 32'(opc0), 32'd0);
        check("rst_zero_count", 32'(zc0), 32'd0);
        check("rst_req_ready", 32'(ready0), 32'd1);
        check("rst_req_ready_lat2", 32'(ready2), 32'd1);
        rst = 1'b0;
        tick();

        // 2/4. table-driven single requests, ALU_LAT=0
        for (int i = 0; i < 6; i++) begin
            check("tbl_ready_idle", 32'(ready0), 32'd1);
            req_valid = 1'b1; req_rs = vecs[i].rs; req_rt = vecs[i].rt;
            req_op = vecs[i].op; req_tag = vecs[i].tag;
            tick();
            req_valid = 1'b0;
            lat = 0;
            do begin
                tick();
                lat++;
            end while (!rv0 && lat < 10);
            check("tbl_latency", 32'(lat), 32'd2);
            check("tbl_result", 32'(rr0), 32'(vecs[i].res));
            check("tbl_set", 32'(rset0), 32'(vecs[i].set));
            check("tbl_zero", 32'(rzero0), 32'(vecs[i].zero));
            check("tbl_tag", 32'(rtag0), 32'(vecs[i].tag));
            check("tbl_opcode_driven", 32'(op0), 32'(vecs[i].op));
            tick();
            exp_ops++;
            if (vecs[i].zero) exp_zeros++;
            check("tbl_valid_cleared", 32'(rv0), 32'd0);
            check("tbl_op_count", 32'(opc0), 32'(exp_ops));
            check("tbl_zero_count", 32'(zc0), 32'(exp_zeros));
            check("tbl_busy_after", 32'(busy0), 32'd0);
            check("tbl_rs_held", 32'(rs0), 32'(vecs[i].rs));
        end

        // 3. back-pressure: 5 requests absorbed, 6th stalls, then in-order drain
        rsp_ready = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_rs = 8'(i * 17); req_rt = 8'h3C;
            req_op = 3'b000; req_tag = 4'(i);
            if (ready0) begin
                acc_n++;
                exp_q.push_back('{req_rs, req_rt, req_tag});
            end
            tick();
        end
        check("bp_accepted", 32'(acc_n), 32'd5);
        req_rs = 8'hA5; req_rt = 8'h3C; req_tag = 4'd5;
        check("bp_ready_low_full", 32'(ready0), 32'd0);
        rsp_ready = 1'b1;
        got = 0; last = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            if (rv0) begin
                check("bp_order_tag", 32'(rtag0), 32'(got));
                check_rsp("bp");
                if (got > 0) check("bp_spacing", 32'(cyc - last), 32'd2);
                last = cyc;
                got++;
            end
            acc = req_valid && ready0;
            if (acc) exp_q.push_back('{req_rs, req_rt, req_tag});
            tick();
            if (acc) req_valid = 1'b0;
        end
        check("bp_responses", 32'(got), 32'd6);
        check("bp_op_count", 32'(opc0), 32'(exp_ops));
        check("bp_zero_count", 32'(zc0), 32'(exp_zeros));

        // random traffic against the queue model
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (rv0 && rsp_ready) check_rsp("rnd");
            if (req_valid && ready0) exp_q.push_back('{req_rs, req_rt, req_tag});
            tick();
            req_valid = ($urandom_range(0, 2) != 0);
            req_rs    = 8'($urandom);
            req_rt    = ($urandom_range(0, 3) == 0) ? req_rs : 8'($urandom);
            req_op    = 3'($urandom);
            req_tag   = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && (exp_q.size() != 0 || rv0); cyc++) begin
            if (rv0) check_rsp("drain");
            tick();
        end
        check("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
        check("rnd_op_count", 32'(opc0), 32'(exp_ops));
        check("rnd_zero_count", 32'(zc0), 32'(exp_zeros));
        check("rnd_busy_idle", 32'(busy0), 32'd0);

        // 6. reset while holding a response with three requests queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_rs = 8'(i + 1); req_rt = 8'h00; req_tag = 4'(12 + i);
            check("pre_rst_ready", 32'(ready0), 32'd1);
            tick();
        end
        req_valid = 1'b0;
        tick();
        check("pre_rst_hold_valid", 32'(rv0), 32'd1);
        check("pre_rst_busy", 32'(busy0), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_rsp_valid", 32'(rv0), 32'd0);
        check("mid_rst_busy", 32'(busy0), 32'd0);
        check("mid_rst_op_count", 32'(opc0), 32'd0);
        check("mid_rst_zero_count", 32'(zc0), 32'd0);
        check("mid_rst_ready", 32'(ready0), 32'd1);
        check("mid_rst_rs", 32'(rs0), 32'd0);
        rsp_ready = 1'b1;
        stale = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            tick();
            if (rv0 || busy0) stale++;
        end
        check("post_rst_no_stale", 32'(stale), 32'd0);
        check("post_rst_op_count", 32'(opc0), 32'd0);

        // 5. ALU_LAT=2 instance: operands held while waiting, 4-cycle latency
        check("lat2_ready", 32'(ready2), 32'd1);
        req_valid = 1'b1; req_rs = 8'h0F; req_rt = 8'hF0; req_op = 3'b010; req_tag = 4'd3;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("lat2_not_yet_valid", 32'(rv2), 32'd0);
            check("lat2_rs_stable", 32'(rs2), 32'h0F);
            check("lat2_rt_stable", 32'(rt2), 32'hF0);
        end
        tick();
        check("lat2_valid_at_4", 32'(rv2), 32'd1);
        check("lat2_result", 32'(rr2), 32'hFF);
        check("lat2_set", 32'(rset2), 32'd1);
        check("lat2_zero", 32'(rzero2), 32'd0);
        check("lat2_tag", 32'(rtag2), 32'd3);
        tick();
        check("lat2_valid_cleared", 32'(rv2), 32'd0);
        check("lat2_op_count", 32'(opc2), 32'd1);
        check("lat2_busy_after", 32'(busy2), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
